turbo_encoder_top: RTL and testbench
====================================

# turbo_encoder_top

Rate-1/3 turbo encoder with trellis termination. It accepts one 256-bit information block as four 64-bit words and writes 262 channel words of 48 bits each, numbered 0..261. Each channel word holds three 16-bit BPSK soft values {systematic, parity1, parity2}. This is the transmit-side counterpart of the turbo decoder top: the output word format, word count and word order match the 48-bit channel memory that the decoder loads.

## Interface
- `MAG`, default 16'sd1024: BPSK amplitude. Bit 0 maps to +MAG, bit 1 maps to -MAG, as 16-bit two's complement.
- `K`, default 256: information bits per block. Fixed; no other value is supported.
- `clk_dp` in 1: processing clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `data_in` in 64: information word. Bit 0 of word 0 is info bit u[0], and bit j of word w is u[64w+j].
- `in_valid` in 1: `data_in` is valid this cycle.
- `in_ready` out 1: the block can accept a word. A word is accepted on a cycle where `in_valid` and `in_ready` are both high.
- `data_out` out 48: channel word. [47:32] is systematic, [31:16] is parity1, [15:0] is parity2.
- `addr_out` out 9: channel word index, 0..261.
- `we_encode` out 1: `data_out` and `addr_out` are valid this cycle. The sink cannot stall this output.
- `busy` out 1: high in ENC, TAIL1 and TAIL2.
- `done` out 1: one-cycle pulse in the same cycle as the write of word 261.

## Operation
- **States:** IDLE, LOAD, ENC, TAIL1, TAIL2.
- **IDLE:**
  - `in_ready`=1.
  - The first accepted word goes to buffer word 0 and the state moves to LOAD.
- **LOAD:**
  - `in_ready`=1.
  - The word counter advances on each accepted word.
  - After the 4th accepted word, the next state is ENC.
  - Gaps in `in_valid` are allowed and add no penalty.
- **ENC:**
  - `in_ready`=0.
  - Bit index i runs 0..255, one bit per cycle.
  - RSC1 takes u[i]. RSC2 takes u[Π(i)].
- **Interleaver:** QPP, Π(i) = (15·i + 32·i²) mod 256.
  - Generated incrementally: Π(0)=0, g(0)=47, Π(i+1)=(Π(i)+g(i)) mod 256, g(i+1)=(g(i)+64) mod 256.
  - All interleaver arithmetic is 8-bit and wraps naturally.
  - No multipliers.
- **Constituent RSC encoders:** LTE style, g0=13 (feedback), g1=15 (forward), octal.
  - State (s1,s2,s3) is zeroed at ENC entry.
  - a = u ^ s2 ^ s3; z = a ^ s1 ^ s3; next state = (a, s1, s2).
- **Systematic word i:** {map(u[i]), map(z1), map(z2)}.
- **TAIL1:** 3 cycles, producing words 256..258.
  - RSC1 is driven with u = s2^s3, so a = 0.
  - Word = {map(u), map(z1), +MAG}.
  - RSC2 holds its state.
- **TAIL2:** 3 cycles, producing words 259..261.
  - Same rule applied to RSC2.
  - Word = {map(u'), +MAG, map(z2)}.
  - After word 261, both encoders are in state 0 and the state returns to IDLE.
- **Info buffer:** a 256-bit register. It is not modified during ENC, TAIL1 or TAIL2.
- **Reset** (`rst`=0, at any cycle, including mid-ENC or mid-LOAD):
  - State goes to IDLE and counters clear.
  - The partial block is discarded and no further words are written.
  - Output values during reset: `in_ready`=0, `we_encode`=0, `busy`=0, `done`=0, `addr_out`=0, `data_out`=0.
  - `in_ready` rises on the first cycle after `rst` returns high.

## Timing
- **Output registering:** outputs are registered. The bit processed in cycle t appears on `data_out`/`addr_out`/`we_encode` in cycle t+1.
- **Start of output:** the 4th word is accepted in cycle T. ENC begins in T+1, and word 0 is written in T+2.
- **Output stream:** `we_encode` is high for 262 consecutive cycles, T+2..T+263. `addr_out` increments by 1 each cycle with no gaps.
- **End of block:** `done`=1 in cycle T+263. `busy` falls in T+263 (IDLE entered). `in_ready`=1 in T+263 and stays high in IDLE.
- **Throughput:** 4 + 262 cycles per block when `in_valid` is held high. The next block's load does not overlap encoding.
- **Input acceptance:** `in_valid` while `in_ready`=0 is ignored; the data is not stored.

## Test plan
- **Reset values:** hold `rst`=0 for 5 cycles -> all outputs 0. Release reset -> `in_ready`=1 on the next cycle.
- **All-zero block:** 4 words of 0 -> 262 writes, each `data_out`=48'h0400_0400_0400, `addr_out` 0..261 contiguous. `done` coincides with addr 261.
- **All-ones block:**
  - Word 0 = 48'hFC00_FC00_FC00.
  - Word 1: sys = -MAG; RSC1 state after step 0 is (1,0,0), so z1 = 1^0^0^1^0 = 0, and p1 = +MAG.
  - Check every output word against a bit-exact reference model, including tails 256..261 returning both encoders to state 0.
- **Impulse at u[0] only:**
  - p1 for words 0..4 = -,-,-,-,+ (z1 = 1,1,1,1,0).
  - p2 word 0 = -MAG (Π(0)=0).
  - sys is -MAG only at word 0.
- **Interleaver check:** impulse at u[47] -> p2 of word 1 = -MAG and sys of word 1 = +MAG. Impulse at u[158] -> p2 of word 2 = -MAG. Impulse at u[77] -> p2 of word 3 = -MAG.
- **Handshake and reset abort:**
  - Toggle `in_valid` randomly during load -> output identical to the gap-free load.
  - Assert `rst`=0 at word 100 of ENC -> `we_encode` is 0 from the next cycle, and no `done`.
  - A new block loaded after reset encodes correctly.

Source files
------------

// File: rtl/turbo_encoder_top.sv
// Rate-1/3 LTE-style turbo encoder with QPP interleaver and trellis termination.
// Ports: clk_dp/rst (sync, active-low); data_in/in_valid/in_ready load four 64-bit
//   info words; data_out/addr_out/we_encode stream 262 channel words {sys,p1,p2};
//   busy covers encoding and tails, done pulses with the write of word 261.
module turbo_encoder_top #(
   parameter logic signed [15:0] MAG = 16'sd1024,
   parameter int                 K   = 256
) (
   input  logic        clk_dp,
   input  logic        rst,
   input  logic [63:0] data_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [47:0] data_out,
   output logic [8:0]  addr_out,
   output logic        we_encode,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ENC   = 3'd2,
      TAIL1 = 3'd3,
      TAIL2 = 3'd4
   } state_t;

   localparam logic [15:0] POS      = MAG;
   localparam logic [15:0] NEG      = 16'(-MAG);
   localparam logic [7:0]  LAST_BIT = 8'(K - 1);

   function automatic logic [15:0] bpsk(input logic b);
      return b ? NEG : POS;
   endfunction

   state_t      state_q, state_d;
   logic [1:0]  word_cnt_q, word_cnt_d;
   logic [7:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  tail_cnt_q, tail_cnt_d;
   logic [7:0]  pi_q, pi_d;        // interleaved read index for RSC2
   logic [7:0]  g_q, g_d;          // QPP first difference
   logic [2:0]  r1_q, r1_d;        // RSC1 state: [0]=s1 [1]=s2 [2]=s3
   logic [2:0]  r2_q, r2_d;        // RSC2 state, same layout
   logic [K-1:0] info_q;

   logic        in_ready_d, busy_d, we_d, done_d;
   logic [47:0] dat_d;
   logic [8:0]  addr_d;

   logic        accept;
   logic        u1, u2;
   logic        a1, a2, z1, z2;
   logic        t_u, t_z;

   // in_ready is a register so it reads 0 while reset is held even though the
   // state is already IDLE; acceptance must use the registered value.
   assign accept = in_valid && in_ready;
   assign u1     = info_q[bit_idx_q];
   assign u2     = info_q[pi_q];

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      bit_idx_d  = bit_idx_q;
      tail_cnt_d = tail_cnt_q;
      pi_d       = pi_q;
      g_d        = g_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      we_d       = 1'b0;
      done_d     = 1'b0;
      dat_d      = '0;
      addr_d     = '0;
      a1         = 1'b0;
      a2         = 1'b0;
      z1         = 1'b0;
      z2         = 1'b0;
      t_u        = 1'b0;
      t_z        = 1'b0;

      unique case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               word_cnt_d = word_cnt_q + 2'd1;
               if (word_cnt_q == 2'd3) begin
                  state_d   = ENC;
                  bit_idx_d = '0;
                  pi_d      = '0;
                  g_d       = 8'd47;
                  r1_d      = '0;
                  r2_d      = '0;
               end else begin
                  state_d = LOAD;
               end
            end
         end

         ENC: begin
            a1   = u1 ^ r1_q[1] ^ r1_q[2];
            z1   = a1 ^ r1_q[0] ^ r1_q[2];
            a2   = u2 ^ r2_q[1] ^ r2_q[2];
            z2   = a2 ^ r2_q[0] ^ r2_q[2];
            r1_d = {r1_q[1], r1_q[0], a1};
            r2_d = {r2_q[1], r2_q[0], a2};
            we_d   = 1'b1;
            dat_d  = {bpsk(u1), bpsk(z1), bpsk(z2)};
            addr_d = {1'b0, bit_idx_q};
            bit_idx_d = bit_idx_q + 8'd1;
            // Second-order QPP recurrence: pi += g, g += 2*32 (mod 256).
            pi_d = pi_q + g_q;
            g_d  = g_q + 8'd64;
            if (bit_idx_q == LAST_BIT) begin
               state_d    = TAIL1;
               tail_cnt_d = '0;
            end
         end

         TAIL1: begin
            // Feeding u = s2^s3 forces the feedback bit a to 0, flushing the state.
            t_u  = r1_q[1] ^ r1_q[2];
            t_z  = r1_q[0] ^ r1_q[2];
            r1_d = {r1_q[1], r1_q[0], 1'b0};
            we_d   = 1'b1;
            dat_d  = {bpsk(t_u), bpsk(t_z), POS};
            addr_d = 9'd256 + {7'd0, tail_cnt_q};
            tail_cnt_d = tail_cnt_q + 2'd1;
            if (tail_cnt_q == 2'd2) begin
               state_d    = TAIL2;
               tail_cnt_d = '0;
            end
         end

         TAIL2: begin
            t_u  = r2_q[1] ^ r2_q[2];
            t_z  = r2_q[0] ^ r2_q[2];
            r2_d = {r2_q[1], r2_q[0], 1'b0};
            we_d   = 1'b1;
            dat_d  = {bpsk(t_u), POS, bpsk(t_z)};
            addr_d = 9'd259 + {7'd0, tail_cnt_q};
            tail_cnt_d = tail_cnt_q + 2'd1;
            if (tail_cnt_q == 2'd2) begin
               state_d    = IDLE;
               tail_cnt_d = '0;
               word_cnt_d = '0;
               done_d     = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE) || (state_d == LOAD);
      busy_d     = (state_d == ENC) || (state_d == TAIL1) || (state_d == TAIL2);
   end

   always_ff @(posedge clk_dp) begin
      if (!rst) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         bit_idx_q  <= '0;
         tail_cnt_q <= '0;
         pi_q       <= '0;
         g_q        <= '0;
         r1_q       <= '0;
         r2_q       <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         we_encode  <= 1'b0;
         done       <= 1'b0;
         data_out   <= '0;
         addr_out   <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         bit_idx_q  <= bit_idx_d;
         tail_cnt_q <= tail_cnt_d;
         pi_q       <= pi_d;
         g_q        <= g_d;
         r1_q       <= r1_d;
         r2_q       <= r2_d;
         in_ready   <= in_ready_d;
         busy       <= busy_d;
         we_encode  <= we_d;
         done       <= done_d;
         data_out   <= dat_d;
         addr_out   <= addr_d;
      end
   end

   // Info buffer needs no reset: a new block always overwrites all four words
   // before it is read, and it is only written in IDLE/LOAD.
   always_ff @(posedge clk_dp) begin
      if (rst && accept && ((state_q == IDLE) || (state_q == LOAD))) begin
         info_q[{word_cnt_q, 6'd0} +: 64] <= data_in;
      end
   end

endmodule

// File: tb/tb_turbo_encoder_top.sv
// Scoreboard bench for turbo_encoder_top: stimulus pushes expected channel words,
// an independent monitor pops and compares on every we_encode cycle.
module tb_turbo_encoder_top;

   logic        clk_dp = 1'b0;
   logic        rst;
   logic [63:0] data_in;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] data_out;
   logic [8:0]  addr_out;
   logic        we_encode;
   logic        busy;
   logic        done;

   always #5 clk_dp = ~clk_dp;

   turbo_encoder_top dut (
      .clk_dp    (clk_dp),
      .rst       (rst),
      .data_in   (data_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .addr_out  (addr_out),
      .we_encode (we_encode),
      .busy      (busy),
      .done      (done)
   );

   localparam logic [15:0] P = 16'h0400;
   localparam logic [15:0] N = 16'hFC00;

   typedef struct {
      logic [47:0] d;
      logic [8:0]  a;
      logic        dn;
   } exp_t;

   exp_t        exp_q[$];
   logic [47:0] got [0:261];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [15:0] m(input logic b);
      return b ? N : P;
   endfunction

   // Reference: direct QPP formula and textbook RSC recursion.
   task automatic push_model(input logic [255:0] u);
      logic x1, x2, x3, y1, y2, y3;
      logic fa, fb, ui, uj, zp, zq;
      int   pi;
      exp_t e;
      x1 = 0; x2 = 0; x3 = 0; y1 = 0; y2 = 0; y3 = 0;
      for (int i = 0; i < 256; i++) begin
         pi = (15 * i + 32 * i * i) % 256;
         ui = u[i];
         uj = u[pi];
         fa = ui ^ x2 ^ x3;  zp = fa ^ x1 ^ x3;
         fb = uj ^ y2 ^ y3;  zq = fb ^ y1 ^ y3;
         x3 = x2; x2 = x1; x1 = fa;
         y3 = y2; y2 = y1; y1 = fb;
         e.d = {m(ui), m(zp), m(zq)}; e.a = 9'(i); e.dn = 1'b0;
         exp_q.push_back(e);
      end
      for (int t = 0; t < 3; t++) begin
         ui = x2 ^ x3; zp = x1 ^ x3;
         x3 = x2; x2 = x1; x1 = 1'b0;
         e.d = {m(ui), m(zp), P}; e.a = 9'(256 + t); e.dn = 1'b0;
         exp_q.push_back(e);
      end
      for (int t = 0; t < 3; t++) begin
         uj = y2 ^ y3; zq = y1 ^ y3;
         y3 = y2; y2 = y1; y1 = 1'b0;
         e.d = {m(uj), P, m(zq)}; e.a = 9'(259 + t); e.dn = (t == 2);
         exp_q.push_back(e);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_dp);
         if (we_encode === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got addr %0d, required no write", addr_out);
            end else begin
               e = exp_q.pop_front();
               chk("data", data_out, e.d);
               chk("addr", 48'(addr_out), 48'(e.a));
               chk("done", 48'(done), 48'(e.dn));
               chk("busy", 48'(busy), 48'(!e.dn));
               if (e.dn) chk("in_ready_at_done", 48'(in_ready), 48'd1);
               got[e.a] = data_out;
            end
         end else if (we_encode === 1'b0) begin
            chk("done_without_write", 48'(done), 48'd0);
         end
      end
   end

   task automatic clear_got();
      for (int i = 0; i < 262; i++) got[i] = '0;
   endtask

   task automatic load_block(input logic [255:0] blk, input bit gaps);
      int n = 0;
      int guard = 0;
      bit acc;
      while (n < 4 && guard < 200) begin
         @(negedge clk_dp);
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         data_in  = in_valid ? blk[n*64 +: 64] : {$urandom(), $urandom()};
         acc = in_valid && in_ready;
         @(posedge clk_dp);
         if (acc) n++;
         guard++;
      end
      if (n < 4) begin
         n_checks++;
         n_fail++;
         $display("FAIL load_timeout: got %0d words accepted, required 4", n);
      end
      @(negedge clk_dp);
      in_valid = 1'b0;
      chk("in_ready_in_enc", 48'(in_ready), 48'd0);
      chk("we_before_first", 48'(we_encode), 48'd0);
      push_model(blk);
      @(negedge clk_dp);
      chk("we_first_word", 48'(we_encode), 48'd1);
   endtask

   task automatic wait_done(input bit junk);
      int c = 0;
      while (exp_q.size() != 0 && c < 400) begin
         @(negedge clk_dp);
         in_valid = junk && !in_ready;
         data_in  = {$urandom(), $urandom()};
         c++;
      end
      in_valid = 1'b0;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL block_timeout: got %0d words outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk_dp);
   endtask

   task automatic run_block(input logic [255:0] blk, input bit gaps, input bit junk);
      clear_got();
      load_block(blk, gaps);
      wait_done(junk);
   endtask

   function automatic logic [255:0] rand_blk();
      logic [255:0] b;
      for (int k = 0; k < 8; k++) b[k*32 +: 32] = $urandom();
      return b;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 48'(in_ready), 48'd0);
      chk({tag, "_we"},       48'(we_encode), 48'd0);
      chk({tag, "_busy"},     48'(busy), 48'd0);
      chk({tag, "_done"},     48'(done), 48'd0);
      chk({tag, "_addr"},     48'(addr_out), 48'd0);
      chk({tag, "_data"},     data_out, 48'd0);
   endtask

   initial begin
      logic [255:0] blk;
      logic [15:0]  p1e [0:4];
      int           c;
      p1e[0] = N; p1e[1] = N; p1e[2] = N; p1e[3] = N; p1e[4] = P;

      rst = 1'b0; in_valid = 1'b0; data_in = '0;
      repeat (5) @(negedge clk_dp);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk_dp);
      chk("in_ready_after_reset", 48'(in_ready), 48'd1);

      // All-zero block
      run_block('0, 1'b0, 1'b0);
      for (int i = 0; i < 262; i++) chk("zero_word", got[i], 48'h0400_0400_0400);

      // All-ones block
      run_block('1, 1'b0, 1'b0);
      chk("ones_w0", got[0], 48'hFC00_FC00_FC00);
      chk("ones_w1_sys", 48'(got[1][47:32]), 48'(N));
      chk("ones_w1_p1",  48'(got[1][31:16]), 48'(P));

      // Impulse at u[0]
      run_block(256'd1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) chk("imp0_p1", 48'(got[i][31:16]), 48'(p1e[i]));
      chk("imp0_p2_w0", 48'(got[0][15:0]), 48'(N));
      chk("imp0_sys_w0", 48'(got[0][47:32]), 48'(N));
      for (int i = 1; i < 6; i++) chk("imp0_sys", 48'(got[i][47:32]), 48'(P));

      // Interleaver spot checks
      blk = 256'd1 << 47;
      run_block(blk, 1'b0, 1'b0);
      chk("imp47_p2_w1",  48'(got[1][15:0]), 48'(N));
      chk("imp47_sys_w1", 48'(got[1][47:32]), 48'(P));
      blk = 256'd1 << 158;
      run_block(blk, 1'b0, 1'b0);
      chk("imp158_p2_w2", 48'(got[2][15:0]), 48'(N));
      blk = 256'd1 << 77;
      run_block(blk, 1'b0, 1'b0);
      chk("imp77_p2_w3", 48'(got[3][15:0]), 48'(N));

      // Random data, gaps on in_valid, ignored in_valid while encoding
      run_block(rand_blk(), 1'b1, 1'b1);
      run_block(rand_blk(), 1'b1, 1'b0);

      // Reset abort at word 100
      clear_got();
      load_block(rand_blk(), 1'b0);
      c = 0;
      while (!(we_encode === 1'b1 && addr_out == 9'd100) && c < 300) begin
         @(negedge clk_dp);
         c++;
      end
      chk("reached_word_100", 48'(addr_out), 48'd100);
      rst = 1'b0;
      @(posedge clk_dp);
      #1 exp_q.delete();
      repeat (3) begin
         @(negedge clk_dp);
         chk("abort_we", 48'(we_encode), 48'd0);
         chk("abort_done", 48'(done), 48'd0);
      end
      check_reset_outputs("abort");
      rst = 1'b1;
      @(negedge clk_dp);
      chk("in_ready_after_abort", 48'(in_ready), 48'd1);
      repeat (3) @(negedge clk_dp);
      chk("idle_no_write", 48'(we_encode), 48'd0);

      // Fresh block after abort
      run_block(rand_blk(), 1'b0, 1'b0);

      chk("queue_empty", 48'(exp_q.size()), 48'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
